// File: rtl/gate_stimulus_checker.sv
// Truth-table driver and checker for a small combinational gate: walks every input
// vector, holds it, samples the gate output and tallies mismatches.
module gate_stimulus_checker #(
  parameter int N_INPUTS    = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GATE_OP     = 0,
  parameter int ERR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                dut_out,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid,
  output logic [1:0]          o_dbg_state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST  = '1;
  localparam logic [ERR_W-1:0]    ERR_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [N_INPUTS-1:0] r_vec;
  logic [HW-1:0]       r_hold;
  logic [N_INPUTS-1:0] r_stim;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err;
  logic [N_INPUTS-1:0] r_ff_vec;
  logic                r_ff_valid;

  logic             w_expected;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

  always_comb begin
    w_expected = &r_vec;
    case (GATE_OP)
      1:       w_expected = |r_vec;
      2:       w_expected = ^r_vec;
      3:       w_expected = ~&r_vec;
      default: w_expected = &r_vec;
    endcase
  end

  assign w_mismatch = (dut_out != w_expected);
  // Saturate rather than wrap so a tiny counter never reports a clean run.
  assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_hold     <= '0;
      r_stim     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_vec      <= '0;
            r_hold     <= '0;
            r_err      <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
            r_pass     <= 1'b0;
            r_stim     <= '0;
            r_busy     <= 1'b1;
            r_state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_hold == HOLD_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        SAMPLE: begin
          // An abort during the sample cycle discards that sample.
          if (abort) begin
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_err <= w_err_next;
            if (w_mismatch && !r_ff_valid) begin
              r_ff_valid <= 1'b1;
              r_ff_vec   <= r_vec;
            end
            if (r_vec == VEC_LAST) begin
              r_stim  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
              r_state <= DONE;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_stim  <= r_vec + 1'b1;
              r_hold  <= '0;
              r_state <= DRIVE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim             = r_stim;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_gate_stimulus_checker.sv
// Bench for gate_stimulus_checker: two instances (AND/8-bit count, OR/2-bit count)
// checked every cycle against a cycle-number based model plus literal expectations.
module tb_gate_stimulus_checker;

  localparam int BIG = 1 << 30;

  logic clk;
  logic rst_n;

  logic       a_start, a_abort, a_dut, a_busy, a_done, a_pass, a_ffv;
  logic [1:0] a_stim, a_ffvec, a_dbg;
  logic [7:0] a_err;
  logic       b_start, b_abort, b_dut, b_busy, b_done, b_pass, b_ffv;
  logic [1:0] b_stim, b_ffvec, b_dbg;
  logic [1:0] b_err;

  // dut_out source: 0 real AND gate, 1 tied low, 2 OR of stim, 3 inverse of expected
  int a_mode = 0;
  int b_mode = 2;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  int m_start[2] = '{-1, -1};
  int m_end[2]   = '{BIG, BIG};
  int m_mode[2]  = '{0, 0};
  int m_h[2]     = '{4, 2};
  int m_op[2]    = '{0, 1};
  int m_emax[2]  = '{255, 3};

  typedef struct {
    int stim;
    int busy;
    int done;
    int pass;
    int err;
    int ffv;
    int ffvec;
  } exp_t;

  function automatic logic gate_fn(int op, logic [1:0] v);
    case (op)
      1:       return |v;
      2:       return ^v;
      3:       return ~&v;
      default: return &v;
    endcase
  endfunction

  function automatic logic feed_fn(int mode, int op, logic [1:0] v);
    case (mode)
      1:       return 1'b0;
      2:       return |v;
      3:       return ~gate_fn(op, v);
      default: return &v;
    endcase
  endfunction

  assign a_dut = feed_fn(a_mode, 0, a_stim);
  assign b_dut = feed_fn(b_mode, 1, b_stim);

  gate_stimulus_checker #(.N_INPUTS(2), .HOLD_CYCLES(4), .GATE_OP(0), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .dut_out(a_dut),
    .stim(a_stim), .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_vec(a_ffvec), .first_fail_valid(a_ffv), .o_dbg_state(a_dbg)
  );

  gate_stimulus_checker #(.N_INPUTS(2), .HOLD_CYCLES(2), .GATE_OP(1), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .dut_out(b_dut),
    .stim(b_stim), .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail_vec(b_ffvec), .first_fail_valid(b_ffv), .o_dbg_state(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: a run accepted at cycle s occupies cycles s..s+tot-1, done at s+tot;
  // vector v is sampled on the edge into cycle s+(v+1)*(H+1)
  function automatic int tot(int i);
    return 4 * (m_h[i] + 1);
  endfunction

  function automatic bit in_run(int i, int c);
    return (m_start[i] >= 0) && (c >= m_start[i]) && (c < m_start[i] + tot(i)) && (c < m_end[i]);
  endfunction

  function automatic bit is_done(int i, int c);
    return (m_start[i] >= 0) && (m_end[i] == BIG) && (c == m_start[i] + tot(i));
  endfunction

  function automatic exp_t model_at(int i, int c);
    exp_t e;
    int   lim;
    int   cnt;
    e   = '{default: 0};
    cnt = 0;
    if (m_start[i] < 0) return e;
    e.busy = int'(in_run(i, c));
    if (e.busy != 0) e.stim = (c - m_start[i]) / (m_h[i] + 1);
    e.done = int'(is_done(i, c));
    lim = (c < m_end[i] - 1) ? c : m_end[i] - 1;
    for (int v = 0; v < 4; v++) begin
      if (m_start[i] + (v + 1) * (m_h[i] + 1) <= lim) begin
        if (feed_fn(m_mode[i], m_op[i], 2'(v)) != gate_fn(m_op[i], 2'(v))) begin
          cnt++;
          if (e.ffv == 0) begin
            e.ffv   = 1;
            e.ffvec = v;
          end
        end
      end
    end
    e.err  = (cnt > m_emax[i]) ? m_emax[i] : cnt;
    e.pass = int'((m_end[i] == BIG) && (c >= m_start[i] + tot(i)) && (cnt == 0));
    return e;
  endfunction

  always @(posedge clk) begin
    logic st, ab;
    int   md;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      st = (i == 0) ? a_start : b_start;
      ab = (i == 0) ? a_abort : b_abort;
      md = (i == 0) ? a_mode : b_mode;
      if (!rst_n) begin
        m_start[i] = -1;
        m_end[i]   = BIG;
      end else if (!in_run(i, cyc - 1) && !is_done(i, cyc - 1) && st && !ab) begin
        m_start[i] = cyc;
        m_end[i]   = BIG;
        m_mode[i]  = md;
      end else if (in_run(i, cyc - 1) && ab) begin
        m_end[i] = cyc;
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    exp_t ea, eb;
    if (cyc >= 1) begin
      ea = rst_n ? model_at(0, cyc) : '{default: 0};
      eb = rst_n ? model_at(1, cyc) : '{default: 0};
      chk("a_stim", int'(a_stim), ea.stim);
      chk("a_busy", int'(a_busy), ea.busy);
      chk("a_done", int'(a_done), ea.done);
      chk("a_pass", int'(a_pass), ea.pass);
      chk("a_err", int'(a_err), ea.err);
      chk("a_ffv", int'(a_ffv), ea.ffv);
      chk("a_ffvec", int'(a_ffvec), ea.ffvec);
      chk("b_stim", int'(b_stim), eb.stim);
      chk("b_busy", int'(b_busy), eb.busy);
      chk("b_done", int'(b_done), eb.done);
      chk("b_pass", int'(b_pass), eb.pass);
      chk("b_err", int'(b_err), eb.err);
      chk("b_ffv", int'(b_ffv), eb.ffv);
      chk("b_ffvec", int'(b_ffvec), eb.ffvec);
    end
  end

  // driver tasks
  task automatic set_start(int i, logic v);
    if (i == 0) a_start = v;
    else        b_start = v;
  endtask

  task automatic pulse_start(int i);
    @(posedge clk);
    #1 set_start(i, 1'b1);
    @(posedge clk);
    #1 set_start(i, 1'b0);
  endtask

  task automatic wait_done(int i, output int busy_n);
    int got;
    busy_n = 0;
    got    = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((i == 0) ? a_done : b_done) begin
        got = 1;
        break;
      end
      if ((i == 0) ? a_busy : b_busy) busy_n++;
    end
    chk("done_seen", got, 1);
  endtask

  initial begin
    int bn;
    int found;
    rst_n   = 1'b0;
    a_start = 1'b0;
    a_abort = 1'b0;
    b_start = 1'b0;
    b_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(a_busy), 0);

    // 1: real AND gate, full clean run
    a_mode = 0;
    pulse_start(0);
    wait_done(0, bn);
    chk("t1_busy_cycles", bn, 20);
    chk("t1_pass", int'(a_pass), 1);
    chk("t1_err", int'(a_err), 0);
    chk("t1_ffv", int'(a_ffv), 0);
    @(negedge clk);
    chk("t1_done_one_cycle", int'(a_done), 0);

    // 2: output stuck low, only vector 11 fails
    a_mode = 1;
    pulse_start(0);
    wait_done(0, bn);
    chk("t2_err", int'(a_err), 1);
    chk("t2_ffvec", int'(a_ffvec), 3);
    chk("t2_ffv", int'(a_ffv), 1);
    chk("t2_pass", int'(a_pass), 0);

    // 3: OR gate against AND expectation, then against OR expectation
    a_mode = 2;
    pulse_start(0);
    wait_done(0, bn);
    chk("t3_err", int'(a_err), 2);
    chk("t3_ffvec", int'(a_ffvec), 1);
    chk("t3_pass", int'(a_pass), 0);
    b_mode = 2;
    pulse_start(1);
    wait_done(1, bn);
    chk("t3b_busy_cycles", bn, 12);
    chk("t3b_pass", int'(b_pass), 1);

    // 4: abort during DRIVE of vector 10, then restart
    a_mode = 0;
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_stim == 2'b10) begin
        found = 1;
        break;
      end
    end
    chk("t4_reach_vec10", found, 1);
    @(posedge clk);
    #1 a_abort = 1'b1;
    @(posedge clk);
    #1 a_abort = 1'b0;
    @(negedge clk);
    chk("t4_busy_after_abort", int'(a_busy), 0);
    chk("t4_stim_after_abort", int'(a_stim), 0);
    found = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (a_done) found = 1;
    end
    chk("t4_no_done", found, 0);
    pulse_start(0);
    @(negedge clk);
    chk("t4_restart_stim", int'(a_stim), 0);
    chk("t4_restart_err", int'(a_err), 0);
    wait_done(0, bn);
    chk("t4_pass", int'(a_pass), 1);

    // 6: every vector wrong with a 2-bit counter; extra starts while busy
    b_mode = 3;
    pulse_start(1);
    repeat (2) @(negedge clk);
    pulse_start(1);
    wait_done(1, bn);
    chk("t6_err_sat", int'(b_err), 3);
    chk("t6_ffvec", int'(b_ffvec), 0);
    chk("t6_pass", int'(b_pass), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_restart", int'(b_busy), 0);

    // 5: asynchronous reset in the SAMPLE cycle of vector 01
    a_mode = 0;
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_stim == 2'b01) begin
        found = 1;
        break;
      end
    end
    chk("t5_reach_vec01", found, 1);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", int'(a_busy), 0);
    chk("t5_async_stim", int'(a_stim), 0);
    chk("t5_async_err", int'(b_err) + int'(a_err), 0);
    chk("t5_async_flags", int'({a_done, a_pass, a_ffv, b_pass}), 0);
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    @(negedge clk);
    chk("t5_start_in_reset", int'(a_busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_after_release", int'(a_busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
